// File: rtl/reg_ext_handshake_ctrl.sv
// Turns one-cycle register read/write strobes into a four-phase req/ack
// transaction toward slow hardware, with completion, read data and timeout error.
module reg_ext_handshake_ctrl #(
  parameter int unsigned DW            = 32,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          re_i,
  input  logic          we_i,
  input  logic [DW-1:0] wd_i,
  output logic          ready_o,
  output logic          error_o,
  output logic [DW-1:0] rdata_o,
  output logic          busy_o,
  output logic          overrun_o,
  output logic          hw_req_o,
  output logic          hw_we_o,
  output logic [DW-1:0] hw_wdata_o,
  input  logic          hw_ack_i,
  input  logic [DW-1:0] hw_rdata_i
);

  localparam int unsigned CW = (TimeoutCycles > 32'd0) ? $clog2(TimeoutCycles + 32'd1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(TimeoutCycles);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            hw_req_q, hw_req_d;
  logic            hw_we_q, hw_we_d;
  logic [DW-1:0]   hw_wdata_q, hw_wdata_d;
  logic            ready_q, ready_d;
  logic            error_q, error_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            busy_q, busy_d;
  logic            overrun_q, overrun_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc_s;
  logic            timeout_s;

  // Saturating increment; a zero TimeoutCycles never fires so the counter just parks.
  assign cnt_inc_s = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1'b1);
  assign timeout_s = (TimeoutCycles != 32'd0) && (cnt_inc_s == TO_VAL);

  // Next-state and next-output computation for the handshake sequencer.
  always_comb begin
    state_d    = state_q;
    hw_req_d   = hw_req_q;
    hw_we_d    = hw_we_q;
    hw_wdata_d = hw_wdata_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    ready_d    = 1'b0;
    error_d    = 1'b0;
    overrun_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (we_i || re_i) begin
          state_d    = REQ;
          hw_req_d   = 1'b1;
          hw_we_d    = we_i;
          hw_wdata_d = wd_i;
          cnt_d      = {CW{1'b0}};
          overrun_d  = we_i && re_i;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        cnt_d     = cnt_inc_s;
        overrun_d = we_i || re_i;
        // Ack wins over a timeout expiring in the same cycle.
        if (hw_ack_i) begin
          if (!hw_we_q) begin
            rdata_d = hw_rdata_i;
          end else begin
            rdata_d = rdata_q;
          end
          ready_d  = 1'b1;
          hw_req_d = 1'b0;
          state_d  = RELEASE;
        end else if (timeout_s) begin
          if (!hw_we_q) begin
            rdata_d = {DW{1'b1}};
          end else begin
            rdata_d = rdata_q;
          end
          ready_d  = 1'b1;
          error_d  = 1'b1;
          hw_req_d = 1'b0;
          state_d  = RELEASE;
        end else begin
          state_d = REQ;
        end
      end
      RELEASE: begin
        overrun_d = we_i || re_i;
        if (!hw_ack_i) begin
          state_d = IDLE;
        end else begin
          state_d = RELEASE;
        end
      end
      default: begin
        state_d  = IDLE;
        hw_req_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; async reset aborts any access without completion.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      hw_req_q   <= 1'b0;
      hw_we_q    <= 1'b0;
      hw_wdata_q <= {DW{1'b0}};
      rdata_q    <= {DW{1'b0}};
      cnt_q      <= {CW{1'b0}};
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hw_req_q   <= hw_req_d;
      hw_we_q    <= hw_we_d;
      hw_wdata_q <= hw_wdata_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign ready_o    = ready_q;
  assign error_o    = error_q;
  assign rdata_o    = rdata_q;
  assign busy_o     = busy_q;
  assign overrun_o  = overrun_q;
  assign hw_req_o   = hw_req_q;
  assign hw_we_o    = hw_we_q;
  assign hw_wdata_o = hw_wdata_q;

endmodule

// File: tb/tb_reg_ext_handshake_ctrl.sv
// Scoreboard bench: stimulus pushes expected completions, a negedge monitor pops and compares.
module tb_reg_ext_handshake_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          ovr_exp = 0;
  int          ovr_seen = 0;

  logic        re_a = 1'b0, we_a = 1'b0, ack_a = 1'b0;
  logic [31:0] wd_a = 32'h0, hw_rdata_a = 32'h0;
  logic        ready_a, error_a, busy_a, overrun_a, hw_req_a, hw_we_a;
  logic [31:0] rdata_a, hw_wdata_a;

  logic        re_b = 1'b0, we_b = 1'b0, ack_b = 1'b0;
  logic [31:0] wd_b = 32'h0, hw_rdata_b = 32'h0;
  logic        ready_b, error_b, busy_b, overrun_b, hw_req_b, hw_we_b;
  logic [31:0] rdata_b, hw_wdata_b;

  typedef struct {
    int          cyc;
    logic        err;
    logic        rd;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  reg_ext_handshake_ctrl #(.DW(32), .TimeoutCycles(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .re_i(re_a), .we_i(we_a), .wd_i(wd_a),
    .ready_o(ready_a), .error_o(error_a), .rdata_o(rdata_a), .busy_o(busy_a),
    .overrun_o(overrun_a), .hw_req_o(hw_req_a), .hw_we_o(hw_we_a),
    .hw_wdata_o(hw_wdata_a), .hw_ack_i(ack_a), .hw_rdata_i(hw_rdata_a)
  );

  reg_ext_handshake_ctrl #(.DW(32), .TimeoutCycles(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .re_i(re_b), .we_i(we_b), .wd_i(wd_b),
    .ready_o(ready_b), .error_o(error_b), .rdata_o(rdata_b), .busy_o(busy_b),
    .overrun_o(overrun_b), .hw_req_o(hw_req_b), .hw_we_o(hw_we_b),
    .hw_wdata_o(hw_wdata_b), .hw_ack_i(ack_b), .hw_rdata_i(hw_rdata_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every completion pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ready_a) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ready: ready_o at cycle %0d, none expected", cyc);
        end else begin
          mon_e = sb_q.pop_front();
          chk("ready_cycle", 32'(cyc), 32'(mon_e.cyc));
          chk("error", 32'(error_a), 32'(mon_e.err));
          if (mon_e.rd) chk("rdata", rdata_a, mon_e.rdata);
        end
      end
      if (error_a && !ready_a) chk("error_without_ready", 32'(ready_a), 32'd1);
      if (overrun_a) ovr_seen++;
    end
  end

  // One access on dut_a; inj_k > 0 drops an extra read strobe at that cycle offset.
  task automatic xact(input logic w, input logic r, input logic [31:0] wd,
                      input int ack_at, input int ack_len, input logic [31:0] hrd,
                      input int inj_k, input int exp_rdy, input logic exp_err,
                      input logic [31:0] exp_rd, input int exp_req_len, input int exp_idle);
    int   req_len;
    int   idle_k;
    exp_t e;
    e.cyc   = cyc + exp_rdy;
    e.err   = exp_err;
    e.rd    = r && !w;
    e.rdata = exp_rd;
    sb_q.push_back(e);
    if (w && r) ovr_exp++;
    we_a = w;
    re_a = r;
    wd_a = wd;
    req_len = 0;
    idle_k  = -1;
    for (int k = 1; k <= 60 && idle_k < 0; k++) begin
      step();
      if (hw_req_a) begin
        req_len++;
        chk("hw_we", 32'(hw_we_a), 32'(w));
        chk("hw_wdata", hw_wdata_a, wd);
      end
      if (k == 1) chk("busy_rise", 32'(busy_a), 32'd1);
      if (k == 1 && w && r) chk("overrun_simul", 32'(overrun_a), 32'd1);
      if (inj_k > 0 && k == inj_k + 1) chk("overrun_busy", 32'(overrun_a), 32'd1);
      if (!busy_a) idle_k = k;
      we_a = 1'b0;
      re_a = 1'b0;
      if (k == inj_k) begin
        re_a = 1'b1;
        ovr_exp++;
      end
      ack_a      = (ack_at > 0) && (k >= ack_at) && (k < ack_at + ack_len);
      hw_rdata_a = ack_a ? hrd : 32'h0;
    end
    ack_a = 1'b0;
    re_a  = 1'b0;
    chk("req_len", 32'(req_len), 32'(exp_req_len));
    chk("idle_cycle", 32'(idle_k), 32'(exp_idle));
  endtask

  initial begin
    int rdy_cnt;
    int req_cnt;
    #3;
    chk("rst_hw_req", 32'(hw_req_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_ready", 32'(ready_a), 32'd0);
    chk("rst_rdata", rdata_a, 32'h0);
    #9 rst_n = 1'b1;
    step();
    step();

    // Write with ack at N+3..N+4.
    xact(1'b1, 1'b0, 32'hDEADBEEF, 3, 2, 32'h0, 0, 4, 1'b0, 32'h0, 3, 6);
    // Read with ack at N+2.
    xact(1'b0, 1'b1, 32'h0, 2, 1, 32'h12345678, 0, 3, 1'b0, 32'h12345678, 2, 4);
    // Minimum-latency write; read data must persist.
    xact(1'b1, 1'b0, 32'hA5A50F0F, 1, 1, 32'h0, 0, 2, 1'b0, 32'h0, 1, 3);
    chk("rdata_hold_write", rdata_a, 32'h12345678);
    // Read timeout.
    xact(1'b0, 1'b1, 32'h0, 0, 0, 32'h0, 0, 5, 1'b1, 32'hFFFFFFFF, 4, 6);
    // Write timeout leaves read data untouched.
    xact(1'b1, 1'b0, 32'h01020304, 0, 0, 32'h0, 0, 5, 1'b1, 32'h0, 4, 6);
    chk("rdata_hold_wr_timeout", rdata_a, 32'hFFFFFFFF);
    // Read with a dropped strobe while in REQ.
    xact(1'b0, 1'b1, 32'h0, 3, 1, 32'h0BADF00D, 1, 4, 1'b0, 32'h0BADF00D, 3, 5);
    // Simultaneous write and read: write wins.
    xact(1'b1, 1'b1, 32'h11112222, 2, 1, 32'h99999999, 0, 3, 1'b0, 32'h0, 2, 4);
    chk("rdata_hold_simul", rdata_a, 32'h0BADF00D);
    // Stuck ack for 12 cycles with a dropped strobe in RELEASE.
    xact(1'b1, 1'b0, 32'h3C3C3C3C, 1, 12, 32'h0, 6, 2, 1'b0, 32'h0, 1, 14);
    // Ack in the last REQ cycle beats the timeout.
    xact(1'b0, 1'b1, 32'h0, 4, 1, 32'h55AA55AA, 0, 5, 1'b0, 32'h55AA55AA, 4, 6);

    // Ack while idle is ignored.
    ack_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_ack_busy", 32'(busy_a), 32'd0);
    end
    ack_a = 1'b0;
    step();

    // Async reset in the middle of REQ.
    re_a = 1'b1;
    step();
    re_a = 1'b0;
    step();
    chk("pre_rst_req", 32'(hw_req_a), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_hw_req", 32'(hw_req_a), 32'd0);
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_rdata", rdata_a, 32'h0);
    chk("mid_rst_hw_wdata", hw_wdata_a, 32'h0);
    chk("mid_rst_hw_we", 32'(hw_we_a), 32'd0);
    chk("mid_rst_flags", {29'h0, ready_a, error_a, overrun_a}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    ack_a = 1'b1;
    hw_rdata_a = 32'hEEEEEEEE;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_req", 32'(hw_req_a), 32'd0);
    end
    ack_a = 1'b0;
    step();
    xact(1'b0, 1'b1, 32'h0, 1, 1, 32'hCAFEF00D, 0, 2, 1'b0, 32'hCAFEF00D, 1, 3);

    // TimeoutCycles = 0: the request waits indefinitely.
    re_b = 1'b1;
    step();
    re_b = 1'b0;
    rdy_cnt = 0;
    req_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready_b) rdy_cnt++;
      if (hw_req_b) req_cnt++;
      step();
    end
    chk("noto_ready_cnt", 32'(rdy_cnt), 32'd0);
    chk("noto_req_cnt", 32'(req_cnt), 32'd40);
    chk("noto_hw_we", 32'(hw_we_b), 32'd0);
    ack_b = 1'b1;
    hw_rdata_b = 32'h76543210;
    step();
    chk("noto_ready", 32'(ready_b), 32'd1);
    chk("noto_error", 32'(error_b), 32'd0);
    chk("noto_rdata", rdata_b, 32'h76543210);
    ack_b = 1'b0;
    step();
    step();
    chk("noto_idle", 32'(busy_b), 32'd0);
    chk("noto_overrun", {31'h0, overrun_b}, 32'd0);
    chk("noto_wdata", hw_wdata_b, 32'h0);

    step();
    step();
    chk("overrun_count", 32'(ovr_seen), 32'(ovr_exp));
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
